sample_dispatcher: RTL

//  Upstream/downstream wrapper for the layer-multiplexed network core. Buffers input

---
 rtl/sample_dispatcher.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/sample_dispatcher.sv
// Sample dispatcher: queues input vectors, launches them into the network core one at a
// time, gathers the per-lane core outputs and returns the vector plus its argmax class.
module sample_dispatcher #(
    parameter int unsigned NEURON_NUM = 6,
    parameter int unsigned ACT_WIDTH  = 9,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 1023
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [NEURON_NUM*ACT_WIDTH-1:0]    in_data,
    output logic                               start,
    output logic [NEURON_NUM*ACT_WIDTH-1:0]    start_input,
    input  logic [NEURON_NUM*ACT_WIDTH-1:0]    final_output,
    input  logic [NEURON_NUM-1:0]              final_output_valid,
    output logic                               result_valid,
    input  logic                               result_ready,
    output logic [NEURON_NUM*ACT_WIDTH-1:0]    result_data,
    output logic [$clog2(NEURON_NUM)-1:0]      result_class,
    output logic                               result_timeout,
    output logic                               busy
);

    localparam int unsigned VEC_W = NEURON_NUM * ACT_WIDTH;
    localparam int unsigned CLS_W = $clog2(NEURON_NUM);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t             state;
    logic [VEC_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [NEURON_NUM-1:0] mask;
    logic [VEC_W-1:0]   cap;
    logic [TMR_W-1:0]   timer;

    logic               push_c;
    logic               pop_c;
    logic [CNT_W-1:0]   count_nxt;
    logic [NEURON_NUM-1:0] mask_nxt;
    logic [VEC_W-1:0]   cap_nxt;
    logic [CLS_W-1:0]   class_nxt;
    logic [ACT_WIDTH-1:0] best_val;
    logic               idle_nxt;
    logic               busy_nxt;

    // FIFO bookkeeping, lane merge of this cycle's core outputs and argmax of the merged vector
    always_comb begin
        push_c    = in_valid && in_ready;
        pop_c     = (state == S_ISSUE);
        count_nxt = CNT_W'(count + CNT_W'(push_c) - CNT_W'(pop_c));
        mask_nxt  = mask | final_output_valid;
        cap_nxt   = cap;
        for (int unsigned i = 0; i < NEURON_NUM; i++) begin
            if (final_output_valid[i]) begin
                cap_nxt[i*ACT_WIDTH +: ACT_WIDTH] = final_output[i*ACT_WIDTH +: ACT_WIDTH];
            end
        end
        best_val  = cap_nxt[ACT_WIDTH-1:0];
        class_nxt = '0;
        for (int unsigned i = 1; i < NEURON_NUM; i++) begin
            if (cap_nxt[i*ACT_WIDTH +: ACT_WIDTH] > best_val) begin
                best_val  = cap_nxt[i*ACT_WIDTH +: ACT_WIDTH];
                class_nxt = CLS_W'(i);
            end
        end
        idle_nxt  = ((state == S_IDLE) && (count == '0)) ||
                    ((state == S_HOLD) && result_ready);
        busy_nxt  = !idle_nxt || (count_nxt != '0);
    end

    // Sample storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Control FSM, FIFO pointers and all registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            mask           <= '0;
            cap            <= '0;
            timer          <= '0;
            in_ready       <= 1'b1;
            busy           <= 1'b0;
            start          <= 1'b0;
            start_input    <= '0;
            result_valid   <= 1'b0;
            result_data    <= '0;
            result_class   <= '0;
            result_timeout <= 1'b0;
        end else begin
            count    <= count_nxt;
            in_ready <= (count_nxt != CNT_W'(FIFO_DEPTH));
            busy     <= busy_nxt;
            start    <= 1'b0;
            if (push_c) begin
                wr_ptr <= PTR_W'(wr_ptr + PTR_W'(1));
            end
            case (state)
                S_IDLE: begin
                    if (count != '0) begin
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    start       <= 1'b1;
                    start_input <= mem[rd_ptr];
                    rd_ptr      <= PTR_W'(rd_ptr + PTR_W'(1));
                    mask        <= '0;
                    cap         <= '0;
                    timer       <= '0;
                    state       <= S_WAIT;
                end
                S_WAIT: begin
                    mask  <= mask_nxt;
                    cap   <= cap_nxt;
                    timer <= TMR_W'(timer + TMR_W'(1));
                    // A complete vector wins over a timeout landing in the same cycle
                    if (&mask_nxt) begin
                        state          <= S_HOLD;
                        result_valid   <= 1'b1;
                        result_data    <= cap_nxt;
                        result_class   <= class_nxt;
                        result_timeout <= 1'b0;
                    end else if (timer == TMR_W'(TIMEOUT)) begin
                        state          <= S_HOLD;
                        result_valid   <= 1'b1;
                        result_data    <= cap_nxt;
                        result_class   <= class_nxt;
                        result_timeout <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
